// File: rtl/egress_pkg.sv
// Shared types and widths for the egress store-and-forward drop buffer.
// Stats counters are built only when EGRESS_DROP_STATS_EN is defined.
package egress_pkg;

    localparam int DATA_W = 512;
    localparam int USER_W = 128;

    function automatic int entry_width(input int dw, input int uw);
        return dw + dw / 8 + uw + 1;
    endfunction

    localparam int ENTRY_W = entry_width(DATA_W, USER_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } wr_state_t;

    typedef enum logic {
        CAUSE_FLAG,
        CAUSE_OVF
    } drop_cause_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PASS,
        EV_FLAG,
        EV_OVF
    } pkt_event_t;

endpackage

// File: rtl/egress_beat_ram.sv
// Simple dual-port beat RAM with one write port and a registered read port.
// The read register doubles as the buffer's output register.
module egress_beat_ram
    import egress_pkg::*;
#(
    parameter int W  = ENTRY_W,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/egress_drop_buffer.sv
// Store-and-forward egress buffer: releases only whole packets, drops flagged
// or overflowing ones by write-pointer rollback. Stats: EGRESS_DROP_STATS_EN.
module egress_drop_buffer
    import egress_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = USER_W,
    parameter int DEPTH_LOG2           = 6,
    parameter int DROP_BIT             = 127
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [31:0]                       stat_pass_cnt,
    output logic [31:0]                       stat_drop_flag_cnt,
    output logic [31:0]                       stat_drop_ovf_cnt
);

    localparam int EW = entry_width(C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << DEPTH_LOG2;

    wr_state_t   state;
    drop_cause_t cause;
    pkt_event_t  evt;
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, wr_nxt;
    logic ready_q, accept, full, flag, we, re, m_valid_q;
    logic [EW-1:0] rd_entry;

    assign s_axis_tready = ready_q & aresetn;
    assign accept = s_axis_tvalid & s_axis_tready;
    assign full   = (wr_ptr - rd_ptr) == DEPTH;
    assign flag   = s_axis_tuser[DROP_BIT];
    assign wr_nxt = wr_ptr + 1'b1;

    always_comb begin
        we  = 1'b0;
        evt = EV_NONE;
        if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    we = !flag && !full;
                    if (s_axis_tlast) begin
                        evt = flag ? EV_FLAG : (full ? EV_OVF : EV_PASS);
                    end
                end
                ST_PASS: begin
                    we = !full;
                    if (s_axis_tlast) begin
                        evt = full ? EV_OVF : EV_PASS;
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        evt = (cause == CAUSE_FLAG) ? EV_FLAG : EV_OVF;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            cause     <= CAUSE_FLAG;
            wr_ptr    <= '0;
            wr_commit <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        if (flag || full) begin
                            cause <= flag ? CAUSE_FLAG : CAUSE_OVF;
                            if (!s_axis_tlast) begin
                                state <= ST_DROP;
                            end
                        end else if (s_axis_tlast) begin
                            wr_ptr    <= wr_nxt;
                            wr_commit <= wr_nxt;
                        end else begin
                            wr_ptr <= wr_nxt;
                            state  <= ST_PASS;
                        end
                    end
                    ST_PASS: begin
                        if (full) begin
                            wr_ptr <= wr_commit;
                            cause  <= CAUSE_OVF;
                            state  <= s_axis_tlast ? ST_IDLE : ST_DROP;
                        end else begin
                            wr_ptr <= wr_nxt;
                            if (s_axis_tlast) begin
                                wr_commit <= wr_nxt;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        if (s_axis_tlast) begin
                            wr_ptr <= wr_commit;
                            state  <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Output register is the RAM read register; reload when empty or draining.
    assign re = (rd_ptr != wr_commit) && (!m_valid_q || m_axis_tready);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rd_ptr    <= '0;
            m_valid_q <= 1'b0;
        end else if (re) begin
            rd_ptr    <= rd_ptr + 1'b1;
            m_valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    egress_beat_ram #(
        .W  (EW),
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .aresetn (aresetn),
        .we      (we),
        .waddr   (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata   ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .re      (re),
        .raddr   (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata   (rd_entry)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = rd_entry;
    assign m_axis_tvalid = m_valid_q;

`ifdef EGRESS_DROP_STATS_EN
    logic [31:0] pass_q, flag_q, ovf_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            pass_q <= '0;
            flag_q <= '0;
            ovf_q  <= '0;
        end else begin
            unique case (evt)
                EV_PASS: pass_q <= pass_q + 32'd1;
                EV_FLAG: flag_q <= flag_q + 32'd1;
                EV_OVF:  ovf_q  <= ovf_q + 32'd1;
                default: ;
            endcase
        end
    end

    assign stat_pass_cnt      = pass_q;
    assign stat_drop_flag_cnt = flag_q;
    assign stat_drop_ovf_cnt  = ovf_q;
`else
    logic unused_evt;
    assign unused_evt = ^evt;

    assign stat_pass_cnt      = '0;
    assign stat_drop_flag_cnt = '0;
    assign stat_drop_ovf_cnt  = '0;
`endif

endmodule

// File: tb/tb_egress_drop_buffer.sv
// Directed bench for egress_drop_buffer: pass, flag drop, overflow, stall,
// toggling ready and mid-packet reset; expected beats kept in a queue.
module tb_egress_drop_buffer;

`ifdef EGRESS_DROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [511:0] s_data = '0;
    logic [63:0]  s_keep = '0;
    logic [127:0] s_user = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_last = 1'b0;
    logic [511:0] m_data;
    logic [63:0]  m_keep;
    logic [127:0] m_user;
    logic         m_last;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [31:0]  st_pass, st_flag, st_ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_cyc = -1;
    int e_cyc;
    bit toggling = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    egress_drop_buffer dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .s_axis_tdata       (s_data),
        .s_axis_tkeep       (s_keep),
        .s_axis_tuser       (s_user),
        .s_axis_tvalid      (s_valid),
        .s_axis_tready      (s_ready),
        .s_axis_tlast       (s_last),
        .m_axis_tdata       (m_data),
        .m_axis_tkeep       (m_keep),
        .m_axis_tuser       (m_user),
        .m_axis_tlast       (m_last),
        .m_axis_tvalid      (m_valid),
        .m_axis_tready      (m_ready),
        .stat_pass_cnt      (st_pass),
        .stat_drop_flag_cnt (st_flag),
        .stat_drop_ovf_cnt  (st_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input int id, input int b,
                                              input bit last);
        logic [7:0] k;
        k = last ? 8'h0F : 8'hFF;
        return {last, 7'd0, k, id[15:0], id[15:0], b[15:0]};
    endfunction

    function automatic logic [63:0] st(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    // Every visible beat must equal the queue head; pop only on handshake.
    always @(negedge clk) begin
        if (aresetn && m_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_beat", {63'd0, m_valid}, 64'd0);
            end else begin
                check("beat", {m_last, 7'd0, m_keep[7:0], m_user[15:0],
                               m_data[31:0]}, exp_q[0]);
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_beat(input int id, input int b, input bit last,
                              input bit drop_flag);
        s_valid = 1'b1;
        s_last  = last;
        s_data  = {16{id[15:0], b[15:0]}};
        s_keep  = last ? 64'h0F : '1;
        s_user  = '0;
        s_user[15:0] = id[15:0];
        s_user[127]  = drop_flag;
    endtask

    task automatic send(input int id, input int n, input bit drop_flag,
                        input bit pass);
        for (int b = 0; b < n; b++) begin
            drive_beat(id, b, b == n - 1, drop_flag);
            if (pass) exp_q.push_back(beat_word(id, b, b == n - 1));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", {63'd0, s_ready}, 64'd0);
        check("rst_tvalid", {63'd0, m_valid}, 64'd0);
        check("rst_tdata", m_data[63:0], 64'd0);
        check("rst_tlast", {63'd0, m_last}, 64'd0);
        check("rst_pass", 64'(st_pass), 64'd0);
        check("rst_flag", 64'(st_flag), 64'd0);
        check("rst_ovf", 64'(st_ovf), 64'd0);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("tready_up", {63'd0, s_ready}, 64'd1);

        first_cyc = -1;
        send(1, 3, 1'b0, 1'b1);
        e_cyc = cyc;
        check("t1_no_early", {63'd0, m_valid}, 64'd0);
        wait_drain("t1_drain");
        check("t1_latency", 64'(first_cyc - e_cyc), 64'd1);
        check("t1_pass", 64'(st_pass), st(1));

        send(2, 2, 1'b1, 1'b0);
        send(3, 1, 1'b0, 1'b1);
        wait_drain("t2_drain");
        check("t2_flag", 64'(st_flag), st(1));
        check("t2_pass", 64'(st_pass), st(2));

        send(4, 70, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_out", {63'd0, m_valid}, 64'd0);
        check("t3_ovf", 64'(st_ovf), st(1));
        send(5, 4, 1'b0, 1'b1);
        wait_drain("t3_drain");
        check("t3_pass", 64'(st_pass), st(3));

        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(10 + i, 4, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_ovf", 64'(st_ovf), st(1));
        send(30, 4, 1'b0, 1'b0);
        check("t4_ovf", 64'(st_ovf), st(2));
        check("t4_held", {63'd0, m_valid}, 64'd1);
        check("t4_queued", 64'(exp_q.size()), 64'd64);
        m_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_pass", 64'(st_pass), st(19));

        toggling = 1'b1;
        fork
            begin
                while (toggling) begin
                    @(posedge clk);
                    #1;
                    m_ready = ~m_ready;
                end
            end
        join_none
        send(40, 3, 1'b0, 1'b1);
        send(41, 3, 1'b0, 1'b1);
        wait_drain("t5_drain");
        toggling = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        check("t5_pass", 64'(st_pass), st(21));

        m_ready = 1'b0;
        send(50, 2, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_held", {63'd0, m_valid}, 64'd1);
        for (int b = 0; b < 2; b++) begin
            drive_beat(51, b, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        check("t6_tready_rst", {63'd0, s_ready}, 64'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_stale", {63'd0, m_valid}, 64'd0);
        check("t6_pass0", 64'(st_pass), 64'd0);
        check("t6_flag0", 64'(st_flag), 64'd0);
        check("t6_ovf0", 64'(st_ovf), 64'd0);
        send(52, 2, 1'b0, 1'b1);
        wait_drain("t6_drain");
        check("t6_pass", 64'(st_pass), st(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
